output_packer: RTL
==================

Name: output_packer

Overview:
- Downstream stage of the convolution/score engine: consumes one signed 16-bit result per output neuron over a valid/ready handshake.
- Binarises each result against a threshold and packs the bits LSB-first into 16-bit words.
- Writes each completed word to the output RAM (dom port group) and raises finish when the neuron stream ends.

Parameters:
- DATA_W, 16, width of incoming sums and of output RAM words
- ADDR_W, 3, output RAM address width
- WORDS, 8, number of output RAM words available (must be <= 2**ADDR_W)
- THRESHOLD, 16'sd0, signed compare value; a sum >= THRESHOLD produces bit 1

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- xxx__dut__go  in  1  single-cycle start pulse; clears packer state and begins collection
- in_valid  in  1  result available from upstream
- in_ready  out  1  packer accepts a result this cycle
- in_sum  in  DATA_W  signed result value
- in_last  in  1  qualifies in_sum as the final result of the layer
- dut__dom__address  out  ADDR_W  output RAM word address
- dut__dom__data  out  DATA_W  packed word
- dut__dom__enable  out  1  output RAM enable
- dut__dom__write  out  1  output RAM write strobe
- dut__xxx__finish  out  1  high in DONE until the next go
- overflow  out  1  sticky: a result arrived after word WORDS-1 was written without in_last

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; bit_cnt=0, word_addr=0, shift word=0, last_seen=0.
  - All outputs 0: in_ready, dom address/data/enable/write, finish, overflow.
- State IDLE:
  - in_ready=0, dom strobes 0.
  - go=1 -> COLLECT; clears bit_cnt, word_addr, word, last_seen, overflow.
- State COLLECT:
  - in_ready=1. A transfer occurs when in_valid && in_ready.
  - On transfer: word[bit_cnt] = ($signed(in_sum) >= THRESHOLD); bit_cnt++.
  - Transfer with bit_cnt==15 or in_last=1 -> WRITE. in_last also sets last_seen.
  - No transfer -> stay in COLLECT, no change.
- State WRITE (exactly 1 cycle):
  - in_ready=0; dom enable=1, write=1, address=word_addr, data=word.
  - Bits above the last accepted bit are 0.
  - Next state:
    - last_seen=1 -> DONE.
    - Else word_addr==WORDS-1 -> OVERFLOW_WAIT.
    - Else word_addr++, bit_cnt=0, word=0 -> COLLECT.
- State OVERFLOW_WAIT:
  - in_ready=1; every transfer is discarded and sets overflow=1.
  - Transfer with in_last=1 -> DONE.
- State DONE:
  - finish=1, in_ready=0.
  - go=1 -> COLLECT, with the same clears as from IDLE (overflow also cleared).
- Latency: the last bit of a word is accepted in cycle N; the RAM write is driven in cycle N+1. Throughput is 16 results per 17 cycles.
- go outside IDLE/DONE is ignored; an in-progress layer is unaffected.
- dom address/data hold their last values when enable=0. Only enable and write are guaranteed 0 outside WRITE.
- Reset asserted mid-operation aborts immediately: no partial write, finish=0.
- in_last on the 16th bit of a word produces a single write, not an extra empty word.
- Zero results then go: no write, state stays COLLECT.

Test Plan:
- Reset then go, 16 sums alternating +5/-5 (first +5), last on 16th -> one write: addr 0, data 16'h5555; finish=1 next cycle; overflow=0.
- 20 sums all 16'h0000, last on 20th -> writes addr0=16'hFFFF, then addr1=16'h000F; finish asserted after the second write.
- Stalled stream: in_valid toggling with gaps of 0–3 cycles, 32 sums of 16'h8000 (negative) -> addr0=16'h0000, addr1=16'h0000; in_ready low during each WRITE cycle; no result lost or duplicated.
- 130 sums all +1, last on 130th -> 8 writes of 16'hFFFF at addr 0..7; results 129–130 discarded; overflow=1; finish=1; no 9th write.
- reset pulled low for 1 cycle after 10 accepted sums -> all outputs 0 immediately; a subsequent go with 3 sums (+1, -1, +1, last) writes addr0=16'h0005.
- go pulse during COLLECT after 4 accepted sums -> ignored: bit_cnt continues; 12 more sums of +1 with last give addr0=16'hFFF0 when the first four sums were negative.

Source files
------------

// File: rtl/output_packer.sv
// output_packer: binarises signed results against THRESHOLD and packs them LSB-first
// into DATA_W-bit words written to the output RAM; raises finish at end of layer.
`default_nettype none

module output_packer #(
    parameter int                         DATA_W    = 16,
    parameter int                         ADDR_W    = 3,
    parameter int                         WORDS     = 8,
    parameter logic signed [DATA_W-1:0]   THRESHOLD = 16'sd0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              xxx__dut__go,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_sum,
    input  logic              in_last,
    output logic [ADDR_W-1:0] dut__dom__address,
    output logic [DATA_W-1:0] dut__dom__data,
    output logic              dut__dom__enable,
    output logic              dut__dom__write,
    output logic              dut__xxx__finish,
    output logic              overflow
);

    localparam int                CNT_W     = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_W - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_COLLECT  = 3'd1;
    localparam logic [2:0] S_WRITE    = 3'd2;
    localparam logic [2:0] S_OVF_WAIT = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    logic [2:0]        state_q,     state_d;
    logic [CNT_W-1:0]  bit_cnt_q,   bit_cnt_d;
    logic [ADDR_W-1:0] word_addr_q, word_addr_d;
    logic [DATA_W-1:0] word_q,      word_d;
    logic              last_seen_q, last_seen_d;
    logic              overflow_q,  overflow_d;
    logic [ADDR_W-1:0] dom_addr_q,  dom_addr_d;
    logic [DATA_W-1:0] dom_data_q,  dom_data_d;

    logic xfer;
    logic start;

    assign in_ready          = (state_q == S_COLLECT) || (state_q == S_OVF_WAIT);
    assign xfer              = in_valid && in_ready;
    assign start             = xxx__dut__go && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign dut__dom__enable  = (state_q == S_WRITE);
    assign dut__dom__write   = (state_q == S_WRITE);
    assign dut__dom__address = dom_addr_q;
    assign dut__dom__data    = dom_data_q;
    assign dut__xxx__finish  = (state_q == S_DONE);
    assign overflow          = overflow_q;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        word_addr_d = word_addr_q;
        word_d      = word_q;
        last_seen_d = last_seen_q;
        overflow_d  = overflow_q;
        dom_addr_d  = dom_addr_q;
        dom_data_d  = dom_data_q;

        if (start) begin
            state_d     = S_COLLECT;
            bit_cnt_d   = '0;
            word_addr_d = '0;
            word_d      = '0;
            last_seen_d = 1'b0;
            overflow_d  = 1'b0;
        end else begin
            case (state_q)
                S_COLLECT: begin
                    if (xfer) begin
                        word_d[bit_cnt_q] = ($signed(in_sum) >= THRESHOLD);
                        bit_cnt_d         = bit_cnt_q + 1'b1;
                        if (in_last) begin
                            last_seen_d = 1'b1;
                        end
                        // Latch the RAM bus here so it is valid for the whole WRITE cycle
                        // and keeps its value afterwards.
                        if ((bit_cnt_q == LAST_BIT) || in_last) begin
                            state_d    = S_WRITE;
                            dom_addr_d = word_addr_q;
                            dom_data_d = word_d;
                        end
                    end
                end
                S_WRITE: begin
                    if (last_seen_q) begin
                        state_d = S_DONE;
                    end else if (word_addr_q == LAST_ADDR) begin
                        state_d = S_OVF_WAIT;
                    end else begin
                        state_d     = S_COLLECT;
                        word_addr_d = word_addr_q + 1'b1;
                        bit_cnt_d   = '0;
                        word_d      = '0;
                    end
                end
                S_OVF_WAIT: begin
                    if (xfer) begin
                        overflow_d = 1'b1;
                        if (in_last) begin
                            state_d = S_DONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            word_addr_q <= '0;
            word_q      <= '0;
            last_seen_q <= 1'b0;
            overflow_q  <= 1'b0;
            dom_addr_q  <= '0;
            dom_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            word_addr_q <= word_addr_d;
            word_q      <= word_d;
            last_seen_q <= last_seen_d;
            overflow_q  <= overflow_d;
            dom_addr_q  <= dom_addr_d;
            dom_data_q  <= dom_data_d;
        end
    end

endmodule

`default_nettype wire
